// File: rtl/cdb_scheduler.sv
// Common data bus scheduler: three execution units (load, add/sub, mul/div),
// each with its own IDLE/EXEC/DONE sequencer, sharing one result broadcast
// bus through a round-robin arbiter.
module cdb_scheduler #(
  parameter int DATA_W  = 6,
  parameter int TAG_W   = 6,
  parameter int LAT_LD  = 5,
  parameter int LAT_ADD = 1,
  parameter int LAT_MUL = 10,
  parameter int LAT_DIV = 40
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [TAG_W-1:0]  ld_tag,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              as_start,
  input  logic              as_op,
  input  logic [DATA_W-1:0] as_a,
  input  logic [DATA_W-1:0] as_b,
  input  logic [TAG_W-1:0]  as_tag,
  input  logic              md_start,
  input  logic              md_op,
  input  logic [DATA_W-1:0] md_a,
  input  logic [DATA_W-1:0] md_b,
  input  logic [TAG_W-1:0]  md_tag,
  output logic              ld_busy,
  output logic              as_busy,
  output logic              md_busy,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_value,
  output logic [1:0]        cdb_src
);

  // Counter must hold the largest latency minus one.
  localparam int LAT_AB  = (LAT_LD > LAT_ADD) ? LAT_LD : LAT_ADD;
  localparam int LAT_CD  = (LAT_MUL > LAT_DIV) ? LAT_MUL : LAT_DIV;
  localparam int LAT_MAX = (LAT_AB > LAT_CD) ? LAT_AB : LAT_CD;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  // Unit index doubles as the cdb_src code: 0=LD, 1=AS, 2=MD.
  localparam logic [1:0] UNIT_MD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } unit_state_t;

  unit_state_t       state_q [3];
  unit_state_t       state_d [3];
  logic [CNT_W-1:0]  cnt_q   [3];
  logic [CNT_W-1:0]  cnt_d   [3];
  logic [DATA_W-1:0] res_q   [3];
  logic [DATA_W-1:0] res_d   [3];
  logic [TAG_W-1:0]  tag_q   [3];
  logic [TAG_W-1:0]  tag_d   [3];

  logic [2:0]        start_v;
  logic [TAG_W-1:0]  tag_in  [3];
  logic [DATA_W-1:0] calc    [3];
  logic [CNT_W-1:0]  lat_m1  [3];

  logic [1:0]        ptr_q;
  logic [2:0]        grant;
  logic              grant_any;
  logic [1:0]        grant_idx;

  // Issue-side datapath: per-unit request, tag, result and latency.
  always_comb begin
    start_v   = {md_start, as_start, ld_start};
    tag_in[0] = ld_tag;
    tag_in[1] = as_tag;
    tag_in[2] = md_tag;
    calc[0]   = ld_data;
    calc[1]   = as_op ? (as_a - as_b) : (as_a + as_b);
    if (md_op) begin
      calc[2] = (md_b == '0) ? '1 : (md_a / md_b);
    end else begin
      calc[2] = md_a * md_b;
    end
    lat_m1[0] = CNT_W'(LAT_LD - 1);
    lat_m1[1] = CNT_W'(LAT_ADD - 1);
    lat_m1[2] = md_op ? CNT_W'(LAT_DIV - 1) : CNT_W'(LAT_MUL - 1);
  end

  // Round-robin arbiter: search DONE units starting after the last grantee.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_any = 1'b0;
    grant_idx = ptr_q;
    for (int k = 1; k <= 3; k++) begin
      if (!grant_any && state_q[(int'(ptr_q) + k) % 3] == S_DONE) begin
        grant_any = 1'b1;
        grant_idx = 2'((int'(ptr_q) + k) % 3);
      end
    end
    grant = grant_any ? (3'b001 << grant_idx) : 3'b000;
  end

  // Next-state logic for the three unit sequencers.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      res_d[i]   = res_q[i];
      tag_d[i]   = tag_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (start_v[i] && tag_in[i] != '0) begin
            state_d[i] = S_EXEC;
            cnt_d[i]   = lat_m1[i];
            res_d[i]   = calc[i];
            tag_d[i]   = tag_in[i];
          end
        end
        S_EXEC: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = S_DONE;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (grant[i]) begin
            state_d[i] = S_IDLE;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  // Busy flags are decoded straight from the sequencer state.
  always_comb begin
    ld_busy = (state_q[0] != S_IDLE);
    as_busy = (state_q[1] != S_IDLE);
    md_busy = (state_q[2] != S_IDLE);
  end

  // State register: unit sequencers, arbiter pointer and broadcast registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are a handful of flops, not a RAM, so every entry is cleared on reset.
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        res_q[i]   <= '0;
        tag_q[i]   <= '0;
      end
      ptr_q     <= UNIT_MD;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        res_q[i]   <= res_d[i];
        tag_q[i]   <= tag_d[i];
      end
      cdb_valid <= grant_any;
      if (grant_any) begin
        cdb_tag   <= tag_q[grant_idx];
        cdb_value <= res_q[grant_idx];
        cdb_src   <= grant_idx;
        ptr_q     <= grant_idx;
      end
    end
  end

endmodule
